// File: rtl/soc_seq_pkg.sv
// soc_seq_pkg: shared types and constants for the SoC test sequencer.
// Optional build macro used by the sequencer: SOC_SEQ_HALT_EN.
package soc_seq_pkg;

   // Sequencer phases
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RESET = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   // Default MISR feedback taps (CRC-32 polynomial)
   localparam logic [31:0] SEQ_DEFAULT_POLY = 32'h04C1_1DB7;

   // Phases in which a run is in progress
   function automatic logic seq_is_busy(input seq_state_t s);
      return (s == ST_RESET) || (s == ST_RUN) || (s == ST_CHECK);
   endfunction

   // Phases in which the SoC is released from reset
   function automatic logic seq_dut_released(input seq_state_t s);
      return (s == ST_RUN) || (s == ST_CHECK) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/soc_seq_misr.sv
// soc_seq_misr: multiple-input signature register compacting one word per
// enabled cycle: sig <= {sig[W-2:0], ^(sig & POLY)} ^ din.
module soc_seq_misr
   import soc_seq_pkg::*;
#(
   parameter int unsigned       DATA_W = 32,
   parameter logic [DATA_W-1:0] POLY   = DATA_W'(SEQ_DEFAULT_POLY)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sig
);

   logic [DATA_W-1:0] sig_q;
   logic              fb;

   // Feedback bit from the tapped signature bits
   always_comb begin
      fb = ^(sig_q & POLY);
   end

   // Signature register: clear has priority over compaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (clr) begin
         sig_q <= '0;
      end else if (en) begin
         sig_q <= {sig_q[DATA_W-2:0], fb} ^ din;
      end
   end

   // Signature output
   always_comb begin
      sig = sig_q;
   end

endmodule

// File: rtl/soc_test_sequencer.sv
// soc_test_sequencer: reset/run controller for the RV32I SoC. Holds the SoC
// in reset, releases it for a fixed run while compacting its observation
// word into a MISR, then compares the signature against an expected value.
// Build macro SOC_SEQ_HALT_EN adds iHALT_VAL: RUN ends early after the
// cycle in which iOBS equals iHALT_VAL.
module soc_test_sequencer
   import soc_seq_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MODE_W     = 2,
   parameter int unsigned SW_W       = 8,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned RUN_CYCLES = 40,
   parameter int unsigned CNT_W      = 16,
   parameter logic [31:0] POLY       = SEQ_DEFAULT_POLY
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic              iABORT,
   input  logic [MODE_W-1:0] iMODE,
   input  logic [SW_W-1:0]   iSW,
   input  logic [DATA_W-1:0] iEXPECT,
   input  logic [DATA_W-1:0] iOBS,
   output logic              oDUT_RST,
   output logic [MODE_W-1:0] oDUT_MODE,
   output logic [SW_W-1:0]   oDUT_SW,
   output logic              oBUSY,
   output logic              oDONE,
   output logic              oPASS,
   output logic [DATA_W-1:0] oSIG,
   output logic [CNT_W-1:0]  oCYCLES
`ifdef SOC_SEQ_HALT_EN
   ,
   input  logic [DATA_W-1:0] iHALT_VAL
`endif
);

   localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
   localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);

   seq_state_t  state;
   seq_state_t  state_nxt;
   logic [31:0] phase;
   logic        start_go;
   logic        misr_en;
   logic        halt_hit;
   logic        run_last;

   // Early-halt match on the observed word
`ifdef SOC_SEQ_HALT_EN
   always_comb begin
      halt_hit = (iOBS == iHALT_VAL);
   end
`else
   always_comb begin
      halt_hit = 1'b0;
   end
`endif

   // Run start/compaction qualifiers; abort overrides both
   always_comb begin
      run_last = (phase == RUN_LAST) || halt_hit;
      start_go = iSTART && !iABORT && ((state == ST_IDLE) || (state == ST_DONE));
      misr_en  = !iABORT && (state == ST_RUN);
   end

   // State register
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (iABORT) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (iSTART) state_nxt = ST_RESET;
            ST_RESET: if (phase == RST_LAST) state_nxt = ST_RUN;
            ST_RUN:   if (run_last) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_DONE;
            ST_DONE:  if (iSTART) state_nxt = ST_RESET;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Phase-decoded outputs; oDUT_RST is decoded from state so it drops
   // together with iRST without waiting for a clock edge
   always_comb begin
      oBUSY    = seq_is_busy(state);
      oDONE    = (state == ST_DONE);
      oDUT_RST = seq_dut_released(state);
   end

   // Run datapath: latched stimulus, phase counter, cycle count, verdict
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oDUT_MODE <= '0;
         oDUT_SW   <= '0;
         oCYCLES   <= '0;
         oPASS     <= 1'b0;
         phase     <= '0;
      end else if (iABORT) begin
         oPASS <= 1'b0;
         phase <= '0;
      end else if (start_go) begin
         oDUT_MODE <= iMODE;
         oDUT_SW   <= iSW;
         oCYCLES   <= '0;
         oPASS     <= 1'b0;
         phase     <= '0;
      end else begin
         case (state)
            ST_RESET: phase <= (phase == RST_LAST) ? '0 : phase + 32'd1;
            ST_RUN: begin
               phase <= phase + 32'd1;
               if (oCYCLES != '1) begin
                  oCYCLES <= oCYCLES + CNT_W'(1);
               end
            end
            ST_CHECK: oPASS <= (oSIG == iEXPECT);
            default: ;
         endcase
      end
   end

   soc_seq_misr #(
      .DATA_W (DATA_W),
      .POLY   (DATA_W'(POLY))
   ) u_misr (
      .clk   (iCLK),
      .rst_n (iRST),
      .clr   (start_go),
      .en    (misr_en),
      .din   (iOBS),
      .sig   (oSIG)
   );

endmodule
